// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully-connected layer, N_OUT MAC lanes fed one input index per cycle.
// Define DENSE_ARGMAX_EN to add the ARGMAX scan state and drive class_idx; otherwise class_idx is 0.
module dense_layer_seq #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 32,
    parameter int W_W    = 32,
    parameter int ACC_W  = 74,
    parameter int AW     = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     relu_en,
    output logic                     busy,
    output logic                     done,
    output logic [AW-1:0]            rd_addr,
    input  logic [DATA_W-1:0]        x_data,
    input  logic [N_OUT*W_W-1:0]     w_data,
    input  logic [N_OUT*ACC_W-1:0]   b_data,
    output logic [N_OUT*ACC_W-1:0]   y,
    output logic [$clog2(N_OUT)-1:0] class_idx
);
    localparam int PW    = DATA_W + W_W;
    localparam int IDX_W = $clog2(N_OUT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_IN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_BIAS, S_ARGMAX, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_addr_q;
    logic            relu_q;
    logic            acc_en_q;
    logic            accept;

`ifdef DENSE_ARGMAX_EN
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N_OUT - 1);
    logic signed [ACC_W-1:0] y_lane [N_OUT];
    logic [IDX_W-1:0]        scan_q, best_idx_q, best_idx_d, class_q;
    logic signed [ACC_W-1:0] best_val_q, best_val_d;
`endif

    assign accept  = (state_q == S_IDLE) && start;
    assign rd_addr = rd_addr_q;

    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_RUN;
            S_RUN:    if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN:  state_d = S_BIAS;
`ifdef DENSE_ARGMAX_EN
            S_BIAS:   state_d = S_ARGMAX;
            S_ARGMAX: if (scan_q == LAST_LANE) state_d = S_DONE;
`else
            S_BIAS:   state_d = S_DONE;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Data returns one cycle after its address, so accumulation trails RUN by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            relu_q    <= 1'b0;
            acc_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_en_q <= (state_q == S_RUN);
            if (accept) begin
                rd_addr_q <= '0;
                relu_q    <= relu_en;
            end else if (state_q == S_RUN && rd_addr_q != LAST_ADDR) begin
                rd_addr_q <= rd_addr_q + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
            logic signed [PW-1:0]    prod;
            logic signed [ACC_W-1:0] sum;
            logic signed [ACC_W-1:0] acc_q;
            logic signed [ACC_W-1:0] y_q;

            assign prod = PW'($signed(x_data)) * PW'($signed(w_data[gi*W_W +: W_W]));
            assign sum  = acc_q + $signed(b_data[gi*ACC_W +: ACC_W]);

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    acc_q <= '0;
                    y_q   <= '0;
                end else begin
                    if (accept)
                        acc_q <= '0;
                    else if (acc_en_q)
                        acc_q <= acc_q + ACC_W'(prod);
                    if (state_q == S_BIAS)
                        y_q <= (relu_q && sum[ACC_W-1]) ? '0 : sum;
                end
            end

            assign y[gi*ACC_W +: ACC_W] = y_q;
`ifdef DENSE_ARGMAX_EN
            assign y_lane[gi] = y_q;
`endif
        end
    endgenerate

`ifdef DENSE_ARGMAX_EN
    // Strict greater-than keeps the earliest lane when values tie.
    always_comb begin
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        if (scan_q == '0 || y_lane[scan_q] > best_val_q) begin
            best_idx_d = scan_q;
            best_val_d = y_lane[scan_q];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_q     <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            class_q    <= '0;
        end else if (state_q == S_BIAS) begin
            scan_q <= '0;
        end else if (state_q == S_ARGMAX) begin
            scan_q     <= scan_q + 1'b1;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            if (scan_q == LAST_LANE)
                class_q <= best_idx_d;
        end
    end

    assign class_idx = class_q;
`else
    assign class_idx = '0;
`endif

endmodule
